// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback unit: result-select codes, state encoding, widths.
package wb_unit_pkg;

  localparam int DATA_W = 32;
  localparam int RF_W   = 5;
  localparam int WSEL_W = 2;
  localparam int CNT_W  = 16;

  localparam logic [WSEL_W-1:0] RF_WSEL_ALUC = 2'd0;
  localparam logic [WSEL_W-1:0] RF_WSEL_RDO  = 2'd1;
  localparam logic [WSEL_W-1:0] RF_WSEL_PC4  = 2'd2;
  localparam logic [WSEL_W-1:0] RF_WSEL_EXT  = 2'd3;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_sel_mux.sv
// 4:1 writeback result select (ALU result, load data, PC+4, extended immediate).
module wb_sel_mux
  import wb_unit_pkg::*;
(
  input  logic [WSEL_W-1:0] i_sel,
  input  logic [DATA_W-1:0] i_aluc,
  input  logic [DATA_W-1:0] i_rdo,
  input  logic [DATA_W-1:0] i_pc4,
  input  logic [DATA_W-1:0] i_ext,
  output logic [DATA_W-1:0] o_wd
);

  always_comb begin
    case (i_sel)
      RF_WSEL_ALUC: o_wd = i_aluc;
      RF_WSEL_RDO:  o_wd = i_rdo;
      RF_WSEL_PC4:  o_wd = i_pc4;
      default:      o_wd = i_ext;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: registers EX results into the register file, waiting for load data with a timeout.
// Optional macro WB_FWD_EN adds forwarding/pending-load observation outputs.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [WSEL_W-1:0] in_wsel,
  input  logic [RF_W-1:0]   in_wr,
  input  logic [DATA_W-1:0] in_aluc,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_ext,
  input  logic              dram_rvalid,
  input  logic [DATA_W-1:0] dram_rdo,
  output logic              rf_we,
  output logic [RF_W-1:0]   rf_wr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              err
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RF_W-1:0]   fwd_wr,
  output logic [DATA_W-1:0] fwd_wd,
  output logic              pend_valid,
  output logic [RF_W-1:0]   pend_wr
`endif
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e         r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_cap_we, w_cap_we_nx;
  logic [RF_W-1:0]   r_cap_wr, w_cap_wr_nx;
  logic              r_rf_we;
  logic [RF_W-1:0]   r_rf_wr;
  logic [DATA_W-1:0] r_rf_wd;
  logic              r_err, w_err_nx;
  logic              w_accept;
  logic              w_fire;
  logic              w_wb_we;
  logic [RF_W-1:0]   w_wb_wr;
  logic [WSEL_W-1:0] w_sel;
  logic [DATA_W-1:0] w_wd;

  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid & in_ready;
  // While a load is pending the only legal data source is the memory return.
  assign w_sel    = (r_state == ST_WAIT_LOAD) ? RF_WSEL_RDO : in_wsel;

  wb_sel_mux u_sel (
    .i_sel  (w_sel),
    .i_aluc (in_aluc),
    .i_rdo  (dram_rdo),
    .i_pc4  (in_pc4),
    .i_ext  (in_ext),
    .o_wd   (w_wd)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_cap_we_nx = r_cap_we;
    w_cap_wr_nx = r_cap_wr;
    w_err_nx    = r_err;
    w_fire      = 1'b0;
    w_wb_we     = 1'b0;
    w_wb_wr     = r_rf_wr;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_wsel == RF_WSEL_RDO) begin
            w_state_nx  = ST_WAIT_LOAD;
            w_cnt_nx    = '0;
            w_cap_we_nx = in_we;
            w_cap_wr_nx = in_wr;
          end else begin
            w_fire  = 1'b1;
            w_wb_we = in_we;
            w_wb_wr = in_wr;
          end
        end
      end
      ST_WAIT_LOAD: begin
        // A return on the final timeout cycle still completes the load.
        if (dram_rvalid) begin
          w_fire     = 1'b1;
          w_wb_we    = r_cap_we;
          w_wb_wr    = r_cap_wr;
          w_state_nx = ST_IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_err_nx   = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cap_we <= 1'b0;
      r_cap_wr <= '0;
      r_rf_we  <= 1'b0;
      r_rf_wr  <= '0;
      r_rf_wd  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_cap_we <= w_cap_we_nx;
      r_cap_wr <= w_cap_wr_nx;
      r_err    <= w_err_nx;
      r_rf_we  <= w_fire & w_wb_we & (w_wb_wr != '0);
      if (w_fire) begin
        r_rf_wr <= w_wb_wr;
        r_rf_wd <= w_wd;
      end
    end
  end

  assign rf_we = r_rf_we;
  assign rf_wr = r_rf_wr;
  assign rf_wd = r_rf_wd;
  assign err   = r_err;

`ifdef WB_FWD_EN
  assign fwd_valid  = r_rf_we;
  assign fwd_wr     = r_rf_wr;
  assign fwd_wd     = r_rf_wd;
  assign pend_valid = (r_state == ST_WAIT_LOAD);
  assign pend_wr    = r_cap_wr;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios followed by random transactions against a transaction-level model.
module tb_wb_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_we;
  logic [1:0]  in_wsel;
  logic [4:0]  in_wr;
  logic [31:0] in_aluc, in_pc4, in_ext;
  logic        dram_rvalid;
  logic [31:0] dram_rdo;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        err;
`ifdef WB_FWD_EN
  logic        fwd_valid, pend_valid;
  logic [4:0]  fwd_wr, pend_wr;
  logic [31:0] fwd_wd;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Model state: the last register-file write seen and the sticky error.
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;
  logic        exp_err;

  wb_unit #(.LOAD_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_we       (in_we),
    .in_wsel     (in_wsel),
    .in_wr       (in_wr),
    .in_aluc     (in_aluc),
    .in_pc4      (in_pc4),
    .in_ext      (in_ext),
    .dram_rvalid (dram_rvalid),
    .dram_rdo    (dram_rdo),
    .rf_we       (rf_we),
    .rf_wr       (rf_wr),
    .rf_wd       (rf_wd),
    .err         (err)
`ifdef WB_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_wr      (fwd_wr),
    .fwd_wd      (fwd_wd),
    .pend_valid  (pend_valid),
    .pend_wr     (pend_wr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ewe, input logic erdy);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(ewe));
    chk({tag, ".rf_wr"}, 32'(rf_wr), 32'(exp_wr));
    chk({tag, ".rf_wd"}, rf_wd, exp_wd);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
`ifdef WB_FWD_EN
    chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(ewe));
    chk({tag, ".fwd_wd"}, fwd_wd, exp_wd);
    chk({tag, ".pend_valid"}, 32'(pend_valid), 32'(!erdy));
`endif
  endtask

  function automatic logic [31:0] pick(input logic [1:0] wsel, input logic [31:0] a,
                                       input logic [31:0] p, input logic [31:0] e);
    case (wsel)
      2'd0:    return a;
      2'd2:    return p;
      default: return e;
    endcase
  endfunction

  // One transaction from an idle unit. delay = cycles after acceptance at which
  // load data returns; delay > TO means the load is left to time out.
  task automatic do_txn(input string tag, input logic [1:0] wsel, input logic we,
                        input logic [4:0] wr, input logic [31:0] aluc, input logic [31:0] pc4,
                        input logic [31:0] ext, input logic [31:0] rdo, input int delay);
    bit done;
    in_valid = 1'b1; in_wsel = wsel; in_we = we; in_wr = wr;
    in_aluc = aluc; in_pc4 = pc4; in_ext = ext;
    dram_rvalid = 1'($urandom); dram_rdo = $urandom;
    tick();
    in_valid = 1'b0; in_wsel = 2'($urandom); in_we = 1'($urandom); in_wr = 5'($urandom);
    in_aluc = $urandom; in_pc4 = $urandom; in_ext = $urandom;
    dram_rvalid = 1'b0;
    if (wsel != 2'd1) begin
      exp_wr = wr;
      exp_wd = pick(wsel, aluc, pc4, ext);
      check_out({tag, ".wb"}, we && (wr != 0), 1'b1);
      tick();
      check_out({tag, ".after"}, 1'b0, 1'b1);
    end else begin
      done = 0;
      for (int k = 1; k <= TO && !done; k++) begin
        chk($sformatf("%s.wait%0d.in_ready", tag, k), 32'(in_ready), 32'd0);
        chk($sformatf("%s.wait%0d.rf_we", tag, k), 32'(rf_we), 32'd0);
        dram_rvalid = (k == delay);
        dram_rdo = (k == delay) ? rdo : $urandom;
        tick();
        dram_rvalid = 1'b0;
        if (k == delay) begin
          exp_wr = wr;
          exp_wd = rdo;
          check_out({tag, ".load"}, we && (wr != 0), 1'b1);
          tick();
          check_out({tag, ".after"}, 1'b0, 1'b1);
          done = 1;
        end
      end
      if (!done) begin
        exp_err = 1'b1;
        check_out({tag, ".timeout"}, 1'b0, 1'b1);
        dram_rvalid = 1'b1; dram_rdo = $urandom;
        tick();
        dram_rvalid = 1'b0;
        check_out({tag, ".late"}, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_wsel = 2'd0; in_wr = 5'd0;
    in_aluc = '0; in_pc4 = '0; in_ext = '0; dram_rvalid = 1'b0; dram_rdo = '0;
    exp_wr = '0; exp_wd = '0; exp_err = 1'b0;
    #12;
    check_out("reset", 1'b0, 1'b1);
    #10 rst = 1'b1;
    tick();
    check_out("post_reset", 1'b0, 1'b1);

    do_txn("aluc", 2'd0, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 0);
    do_txn("load3", 2'd1, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 3);
    do_txn("pc4_x0", 2'd2, 1'b1, 5'd0, 32'h0, 32'h40, 32'h0, 32'h0, 0);
    do_txn("ext", 2'd3, 1'b1, 5'd31, 32'h0, 32'h0, 32'hCAFE0001, 32'h0, 0);
    do_txn("we0", 2'd0, 1'b0, 5'd3, 32'h55AA, 32'h0, 32'h0, 32'h0, 0);
    do_txn("load1", 2'd1, 1'b1, 5'd9, 32'h0, 32'h0, 32'h0, 32'h01020304, 1);
    do_txn("load_edge", 2'd1, 1'b1, 5'd12, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, TO);
    do_txn("load_to", 2'd1, 1'b1, 5'd13, 32'h0, 32'h0, 32'h0, 32'h0, TO + 1);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] ws;
      logic [4:0] wr;
      ws = 2'($urandom);
      wr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        dram_rvalid = 1'($urandom); dram_rdo = $urandom;
        tick();
        dram_rvalid = 1'b0;
        check_out($sformatf("rnd%0d.idle", i), 1'b0, 1'b1);
      end
      do_txn($sformatf("rnd%0d", i), ws, 1'($urandom), wr, $urandom, $urandom, $urandom,
             $urandom, $urandom_range(1, TO + 2));
    end

    in_valid = 1'b1; in_wsel = 2'd1; in_we = 1'b1; in_wr = 5'd9;
    tick();
    in_valid = 1'b0;
    chk("rst_mid.in_ready", 32'(in_ready), 32'd0);
    tick();
    #2 rst = 1'b0;
    #1;
    exp_wr = '0; exp_wd = '0; exp_err = 1'b0;
    check_out("rst_mid.async", 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    dram_rvalid = 1'b1; dram_rdo = 32'h0BADF00D;
    tick();
    dram_rvalid = 1'b0;
    check_out("rst_mid.rvalid", 1'b0, 1'b1);
    tick();
    check_out("rst_mid.settle", 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
